// File: rtl/mul_approx_trunc_pipe.sv
// Pipelined signed WxW multiplier with per-operation exact/approximate mode.
// Approximate mode zeroes the low K bits of A. Elastic valid/ready slots carry a tag sideband.
module mul_approx_trunc_pipe #(
    parameter int W      = 8,
    parameter int K      = 3,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic               in_exact,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_exact
);

    if (W < 2 || W > 32) begin : g_bad_w
        $error("mul_approx_trunc_pipe: W=%0d outside 2..32", W);
    end
    if (K < 0 || K > W - 1) begin : g_bad_k
        $error("mul_approx_trunc_pipe: K=%0d outside 0..W-1", K);
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("mul_approx_trunc_pipe: STAGES=%0d outside 1..4", STAGES);
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("mul_approx_trunc_pipe: TAG_W=%0d must be at least 1", TAG_W);
    end

    // Clearing the low K bits of A equals dropping its K lowest partial-product rows.
    localparam logic [W-1:0] A_MASK = {W{1'b1}} << K;

    logic [W-1:0]                    a_sel_s;
    logic [2*W-1:0]                  a_ext_s;
    logic [2*W-1:0]                  b_ext_s;
    logic [2*W-1:0]                  prod_s;
    logic                            accept_s;
    logic [STAGES-1:0]               load_s;
    logic [STAGES-1:0]               src_v_s;
    logic [STAGES-1:0][2*W-1:0]      src_p_s;
    logic [STAGES-1:0][TAG_W-1:0]    src_tag_s;
    logic [STAGES-1:0]               src_ex_s;
    logic [STAGES-1:0]               v_r;
    logic [STAGES-1:0][2*W-1:0]      p_r;
    logic [STAGES-1:0][TAG_W-1:0]    tag_r;
    logic [STAGES-1:0]               ex_r;

    // Operand selection and sign-extended product; the low 2W bits of the 2W x 2W product are exact.
    always_comb begin
        a_sel_s = in_exact ? in_a : (in_a & A_MASK);
        a_ext_s = {{W{a_sel_s[W-1]}}, a_sel_s};
        b_ext_s = {{W{in_b[W-1]}}, in_b};
        prod_s  = a_ext_s * b_ext_s;
    end

    // Ready chain from the output back to slot 0: a slot loads when empty or when it drains.
    always_comb begin
        logic carry;
        carry  = out_ready;
        load_s = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            load_s[i] = ~v_r[i] | carry;
            carry     = load_s[i];
        end
    end

    assign in_ready = ~rst & load_s[0];
    assign accept_s = in_valid & in_ready;

    // Source of each slot: the input beat for slot 0, the previous slot otherwise.
    always_comb begin
        src_v_s      = '0;
        src_p_s      = '0;
        src_tag_s    = '0;
        src_ex_s     = '0;
        src_v_s[0]   = accept_s;
        src_p_s[0]   = prod_s;
        src_tag_s[0] = in_tag;
        src_ex_s[0]  = in_exact;
        for (int i = 1; i < STAGES; i++) begin
            src_v_s[i]   = v_r[i-1];
            src_p_s[i]   = p_r[i-1];
            src_tag_s[i] = tag_r[i-1];
            src_ex_s[i]  = ex_r[i-1];
        end
    end

    // Slot registers; data only changes when a valid beat moves in, so a stalled output holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r   <= '0;
            p_r   <= '0;
            tag_r <= '0;
            ex_r  <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (load_s[i]) begin
                    v_r[i] <= src_v_s[i];
                    if (src_v_s[i]) begin
                        p_r[i]   <= src_p_s[i];
                        tag_r[i] <= src_tag_s[i];
                        ex_r[i]  <= src_ex_s[i];
                    end
                end
            end
        end
    end

    assign out_valid = v_r[STAGES-1];
    assign out_p     = p_r[STAGES-1];
    assign out_tag   = tag_r[STAGES-1];
    assign out_exact = ex_r[STAGES-1];

endmodule
